// File: rtl/axis_bw_threshold_pkg.sv
// Shared definitions for the binariser: mode encodings (same values as the
// AXI-Lite register block) and the mode decode helper.
package axis_bw_threshold_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_ADAPT  = 2'd2
  } mode_e;

  // Encoding 3 is reserved and behaves as fixed threshold.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    decode_mode = MODE_BYPASS;
      2'd2:    decode_mode = MODE_ADAPT;
      default: decode_mode = MODE_FIXED;
    endcase
  endfunction

endpackage

// File: rtl/bw_pixel_cmp.sv
// Single-pixel binariser: compares one grayscale pixel to the threshold and
// returns an all-ones/all-zeros pixel plus the foreground flag.
module bw_pixel_cmp #(
  parameter int PIX_W   = 8,
  parameter bit DARK_FG = 1'b1
) (
  input  logic [PIX_W-1:0] i_pix,
  input  logic [PIX_W-1:0] i_thr,
  output logic [PIX_W-1:0] o_bw,
  output logic             o_fg
);

  logic w_fg;

  assign w_fg = DARK_FG ? (i_pix <= i_thr) : (i_pix > i_thr);
  assign o_fg = w_fg;
  assign o_bw = {PIX_W{w_fg}};

endmodule

// File: rtl/axis_bw_threshold.sv
// AXI4-Stream grayscale to black/white converter with bypass, fixed and
// adaptive (previous-frame midrange) thresholds and a per-frame foreground count.
module axis_bw_threshold
  import axis_bw_threshold_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int PPB     = 1,
  parameter bit DARK_FG = 1'b1,
  parameter int CNT_W   = 20
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [1:0]           mode,
  input  logic [PIX_W-1:0]     thr_in,
  input  logic [PIX_W*PPB-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tuser,
  input  logic                 s_axis_tlast,
  output logic [PIX_W*PPB-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic [PIX_W-1:0]     thr_active,
  output logic [CNT_W-1:0]     fg_count,
  output logic                 frame_done
);

  localparam int DW    = PIX_W * PPB;
  localparam int POP_W = $clog2(PPB + 1);

  logic             r_init;
  mode_e            r_mode;
  logic [PIX_W-1:0] r_thr;
  logic [PIX_W-1:0] r_min;
  logic [PIX_W-1:0] r_max;
  logic [PIX_W-1:0] r_adapt_thr;
  logic             r_adapt_valid;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_fg_count;
  logic             r_frame_done;
  logic [DW-1:0]    r_tdata;
  logic             r_tvalid;
  logic             r_tuser;
  logic             r_tlast;

  logic             w_accept;
  logic             w_sof;
  logic             w_eof;
  mode_e            w_mode_in;
  mode_e            w_mode_cur;
  mode_e            w_mode_eff;
  logic [PIX_W-1:0] w_thr_cur;
  logic [PIX_W-1:0] w_thr_new;
  logic [PIX_W-1:0] w_thr_eff;
  logic             w_bypass;

  logic [PIX_W-1:0] w_pix_arr [PPB];
  logic [PPB-1:0]   w_fg;
  logic [DW-1:0]    w_out_data;

  logic [PIX_W-1:0] w_beat_min;
  logic [PIX_W-1:0] w_beat_max;
  logic [POP_W-1:0] w_pop;
  logic [PIX_W-1:0] w_min_base;
  logic [PIX_W-1:0] w_max_base;
  logic [PIX_W-1:0] w_min_new;
  logic [PIX_W-1:0] w_max_new;
  logic [PIX_W:0]   w_adapt_sum;
  logic [PIX_W-1:0] w_adapt_thr;
  logic [CNT_W-1:0] w_acc_base;
  logic [CNT_W:0]   w_acc_sum;
  logic [CNT_W-1:0] w_acc_next;

  assign s_axis_tready = !r_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_sof         = w_accept && s_axis_tuser;
  assign w_eof         = w_accept && s_axis_tlast;

  // Until the first clock after reset the live inputs stand in for the
  // sampled mode/threshold, so thr_active follows thr_in out of reset.
  assign w_mode_in  = decode_mode(mode);
  assign w_mode_cur = r_init ? w_mode_in : r_mode;
  assign w_thr_cur  = r_init ? thr_in : r_thr;
  assign w_thr_new  = (w_mode_in == MODE_ADAPT && r_adapt_valid) ? r_adapt_thr : thr_in;
  assign w_mode_eff = w_sof ? w_mode_in : w_mode_cur;
  assign w_thr_eff  = w_sof ? w_thr_new : w_thr_cur;
  assign w_bypass   = (w_mode_eff == MODE_BYPASS);

  generate
    for (genvar gi = 0; gi < PPB; gi++) begin : g_pix
      logic [PIX_W-1:0] w_bw;

      assign w_pix_arr[gi] = s_axis_tdata[gi*PIX_W +: PIX_W];

      bw_pixel_cmp #(
        .PIX_W   (PIX_W),
        .DARK_FG (DARK_FG)
      ) u_cmp (
        .i_pix (w_pix_arr[gi]),
        .i_thr (w_thr_eff),
        .o_bw  (w_bw),
        .o_fg  (w_fg[gi])
      );

      assign w_out_data[gi*PIX_W +: PIX_W] = w_bypass ? w_pix_arr[gi] : w_bw;
    end
  endgenerate

  always_comb begin
    w_beat_min = '1;
    w_beat_max = '0;
    w_pop      = '0;
    for (int i = 0; i < PPB; i++) begin
      if (w_pix_arr[i] < w_beat_min) w_beat_min = w_pix_arr[i];
      if (w_pix_arr[i] > w_beat_max) w_beat_max = w_pix_arr[i];
      w_pop = w_pop + POP_W'(w_fg[i]);
    end
    if (w_bypass) w_pop = '0;
  end

  // A start-of-frame beat discards the running stats before folding itself in.
  assign w_min_base  = w_sof ? '1 : r_min;
  assign w_max_base  = w_sof ? '0 : r_max;
  assign w_min_new   = (w_beat_min < w_min_base) ? w_beat_min : w_min_base;
  assign w_max_new   = (w_beat_max > w_max_base) ? w_beat_max : w_max_base;
  assign w_adapt_sum = {1'b0, w_min_new} + {1'b0, w_max_new} + (PIX_W+1)'(1);
  assign w_adapt_thr = PIX_W'(w_adapt_sum >> 1);

  assign w_acc_base = w_sof ? '0 : r_acc;
  assign w_acc_sum  = {1'b0, w_acc_base} + (CNT_W+1)'(w_pop);
  assign w_acc_next = w_acc_sum[CNT_W] ? '1 : w_acc_sum[CNT_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_init        <= 1'b1;
      r_mode        <= MODE_FIXED;
      r_thr         <= '0;
      r_min         <= '1;
      r_max         <= '0;
      r_adapt_thr   <= '0;
      r_adapt_valid <= 1'b0;
      r_acc         <= '0;
      r_fg_count    <= '0;
      r_frame_done  <= 1'b0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tuser       <= 1'b0;
      r_tlast       <= 1'b0;
    end else begin
      r_init       <= 1'b0;
      r_frame_done <= w_eof;

      if (w_sof) begin
        r_mode <= w_mode_in;
        r_thr  <= w_thr_new;
      end else if (r_init) begin
        r_mode <= w_mode_in;
        r_thr  <= thr_in;
      end

      if (w_accept) begin
        if (s_axis_tlast) begin
          r_adapt_thr   <= w_adapt_thr;
          r_adapt_valid <= 1'b1;
          r_fg_count    <= w_acc_next;
          r_acc         <= '0;
          r_min         <= '1;
          r_max         <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_min <= w_min_new;
          r_max <= w_max_new;
        end
      end

      if (s_axis_tready) begin
        r_tvalid <= s_axis_tvalid;
        if (s_axis_tvalid) begin
          r_tdata <= w_out_data;
          r_tuser <= s_axis_tuser;
          r_tlast <= s_axis_tlast;
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign thr_active    = w_thr_cur;
  assign fg_count      = r_fg_count;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_axis_bw_threshold.sv
// Directed bench for axis_bw_threshold: a PPB=1 instance for the main stream
// tests and a PPB=4 instance for the multi-pixel single-beat frame.
module tb_axis_bw_threshold;

  logic        aclk;
  logic        aresetn;

  logic [1:0]  mode;
  logic [7:0]  thr_in;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic [7:0]  thr_active;
  logic [19:0] fg_count;
  logic        frame_done;

  logic [1:0]  mode4;
  logic [7:0]  thr4_in;
  logic [31:0] s4_tdata;
  logic        s4_tvalid, s4_tready, s4_tuser, s4_tlast;
  logic [31:0] m4_tdata;
  logic        m4_tvalid, m4_tready, m4_tuser, m4_tlast;
  logic [7:0]  thr4_active;
  logic [19:0] fg4_count;
  logic        frame4_done;

  int n_assert = 0;
  int n_fail   = 0;

  axis_bw_threshold #(.PIX_W(8), .PPB(1), .DARK_FG(1'b1), .CNT_W(20)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .mode(mode), .thr_in(thr_in),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .thr_active(thr_active), .fg_count(fg_count), .frame_done(frame_done)
  );

  axis_bw_threshold #(.PIX_W(8), .PPB(4), .DARK_FG(1'b1), .CNT_W(20)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .mode(mode4), .thr_in(thr4_in),
    .s_axis_tdata(s4_tdata), .s_axis_tvalid(s4_tvalid), .s_axis_tready(s4_tready),
    .s_axis_tuser(s4_tuser), .s_axis_tlast(s4_tlast),
    .m_axis_tdata(m4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
    .m_axis_tuser(m4_tuser), .m_axis_tlast(m4_tlast),
    .thr_active(thr4_active), .fg_count(fg4_count), .frame_done(frame4_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded); returns at posedge+1.
  task automatic send(input logic [7:0] pix, input logic u, input logic l);
    logic acc;
    acc      = 1'b0;
    s_tdata  = pix;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = s_tready;
      @(posedge aclk); #1;
    end
    chk("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    @(posedge aclk); #1;
  endtask

  function automatic logic [7:0] t2_pix(input int i);
    t2_pix = 8'((i * 37 + 5) % 256);
  endfunction

  logic [7:0] t1_pix [5];
  logic [7:0] t1_exp [5];
  logic [9:0] held;
  logic       in_fire, out_fire, stalled;
  int         in_idx, out_idx, exp_fg;

  initial begin
    t1_pix = '{8'd99, 8'd100, 8'd101, 8'd0, 8'd255};
    t1_exp = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd0};

    aresetn   = 1'b0;
    mode      = 2'd1;
    thr_in    = 8'd100;
    s_tdata   = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready  = 1'b1;
    mode4     = 2'd2;
    thr4_in   = 8'd100;
    s4_tdata  = '0; s4_tvalid = 1'b0; s4_tuser = 1'b0; s4_tlast = 1'b0;
    m4_tready = 1'b1;

    // reset state
    #3;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_fg_count", fg_count, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_thr_active", thr_active, 32'd100);

    // fixed threshold 100, five-pixel frame
    for (int i = 0; i < 5; i++) begin
      send(t1_pix[i], i == 0, i == 4);
      chk("t1_data", m_tdata, t1_exp[i]);
      chk("t1_valid", {31'd0, m_tvalid}, 32'd1);
    end
    chk("t1_tlast", {31'd0, m_tlast}, 32'd1);
    chk("t1_fg_count", fg_count, 32'd3);
    chk("t1_frame_done", {31'd0, frame_done}, 32'd1);
    idle();
    chk("t1_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("t1_drain", {31'd0, m_tvalid}, 32'd0);

    // 16-beat frame under random backpressure
    exp_fg = 0;
    for (int i = 0; i < 16; i++) if (t2_pix(i) <= 8'd100) exp_fg++;
    in_idx  = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 400 && out_idx < 16; cyc++) begin
      s_tvalid = (in_idx < 16);
      s_tdata  = t2_pix(in_idx);
      s_tuser  = (in_idx == 0);
      s_tlast  = (in_idx == 15);
      m_tready = 1'($urandom_range(0, 1));
      #1;
      in_fire  = s_tvalid && s_tready;
      out_fire = m_tvalid && m_tready;
      stalled  = m_tvalid && !m_tready;
      held     = {m_tdata, m_tuser, m_tlast};
      if (out_fire) begin
        chk("t2_data", m_tdata, (t2_pix(out_idx) <= 8'd100) ? 32'hFF : 32'h0);
        chk("t2_tuser", {31'd0, m_tuser}, {31'd0, out_idx == 0});
        chk("t2_tlast", {31'd0, m_tlast}, {31'd0, out_idx == 15});
        out_idx++;
      end
      @(posedge aclk); #1;
      if (stalled) chk("t2_hold", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, held});
      if (in_fire) in_idx++;
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    chk("t2_beats_out", out_idx, 32'd16);
    chk("t2_fg_count", fg_count, exp_fg);
    idle();

    // asynchronous reset in the middle of a frame
    send(8'd30, 1'b1, 1'b0);
    send(8'd40, 1'b0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mrst_fg_count", fg_count, 32'd0);
    s_tvalid = 1'b0;
    mode     = 2'd2;
    thr_in   = 8'd50;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // adaptive: frame 1 seeded at 50, frame 2 uses (20+200+1)>>1 = 110
    send(8'd20, 1'b1, 1'b0);
    chk("ad1_thr", thr_active, 32'd50);
    chk("ad1_d0", m_tdata, 32'hFF);
    send(8'd200, 1'b0, 1'b0);
    chk("ad1_d1", m_tdata, 32'h0);
    send(8'd100, 1'b0, 1'b0);
    chk("ad1_d2", m_tdata, 32'h0);
    send(8'd60, 1'b0, 1'b1);
    chk("ad1_d3", m_tdata, 32'h0);
    chk("ad1_fg", fg_count, 32'd1);
    send(8'd110, 1'b1, 1'b0);
    chk("ad2_thr", thr_active, 32'd110);
    chk("ad2_d0", m_tdata, 32'hFF);
    send(8'd111, 1'b0, 1'b1);
    chk("ad2_d1", m_tdata, 32'h0);
    chk("ad2_fg", fg_count, 32'd1);
    idle();

    // threshold change mid-frame waits for the next start of frame
    mode   = 2'd1;
    thr_in = 8'd100;
    send(8'd50, 1'b1, 1'b0);
    chk("thr_d0", m_tdata, 32'hFF);
    thr_in = 8'd10;
    send(8'd50, 1'b0, 1'b0);
    chk("thr_d1", m_tdata, 32'hFF);
    chk("thr_hold", thr_active, 32'd100);
    send(8'd50, 1'b0, 1'b1);
    chk("thr_d2", m_tdata, 32'hFF);
    chk("thr_fg1", fg_count, 32'd3);
    send(8'd50, 1'b1, 1'b0);
    chk("thr_new", thr_active, 32'd10);
    chk("thr_d3", m_tdata, 32'h0);
    send(8'd5, 1'b0, 1'b1);
    chk("thr_d4", m_tdata, 32'hFF);
    chk("thr_fg2", fg_count, 32'd1);
    idle();

    // bypass passes pixels and counts nothing
    mode = 2'd0;
    send(8'd77, 1'b1, 1'b0);
    chk("byp_d0", m_tdata, 32'd77);
    send(8'd200, 1'b0, 1'b1);
    chk("byp_d1", m_tdata, 32'd200);
    chk("byp_fg", fg_count, 32'd0);
    chk("byp_done", {31'd0, frame_done}, 32'd1);
    idle();

    // PPB=4 single-beat frames, adaptive seeded at 100 then 105
    s4_tdata  = {8'd10, 8'd200, 8'd10, 8'd200};
    s4_tuser  = 1'b1;
    s4_tlast  = 1'b1;
    s4_tvalid = 1'b1;
    @(posedge aclk); #1;
    chk("p4_thr1", thr4_active, 32'd100);
    chk("p4_data1", m4_tdata, 32'hFF00FF00);
    chk("p4_fg1", fg4_count, 32'd2);
    chk("p4_done1", {31'd0, frame4_done}, 32'd1);
    s4_tdata = {8'd0, 8'd104, 8'd106, 8'd105};
    @(posedge aclk); #1;
    chk("p4_thr2", thr4_active, 32'd105);
    chk("p4_data2", m4_tdata, 32'hFFFF00FF);
    chk("p4_fg2", fg4_count, 32'd3);
    s4_tvalid = 1'b0;
    @(posedge aclk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
